// File: rtl/tmds_channel_encoder_if.sv
// tmds_channel_encoder_if
//   Pixel-side bus of one TMDS lane encoder.
//   master : pixel/timing generator (drives in_*, observes out_*)
//   slave  : tmds_channel_encoder  (consumes in_*, drives out_*)
//   Signals:
//     in_data[7:0]        pixel component
//     in_c0, in_c1        control bits sent during blanking
//     in_blank            1 = blanking, 0 = active video
//     in_island, in_terc4 data-island select and nibble (TMDS_TERC4_EN only)
//     out_tmds[9:0]       encoded symbol, bit 0 transmitted first
//     out_disparity[4:0]  signed running disparity after out_tmds
//   Optional feature macro: TMDS_TERC4_EN
interface tmds_channel_encoder_if;
  logic [7:0]        in_data;
  logic              in_c0;
  logic              in_c1;
  logic              in_blank;
`ifdef TMDS_TERC4_EN
  logic              in_island;
  logic [3:0]        in_terc4;
`endif
  logic [9:0]        out_tmds;
  logic signed [4:0] out_disparity;

`ifdef TMDS_TERC4_EN
  modport master (output in_data, in_c0, in_c1, in_blank, in_island, in_terc4,
                  input  out_tmds, out_disparity);
  modport slave  (input  in_data, in_c0, in_c1, in_blank, in_island, in_terc4,
                  output out_tmds, out_disparity);
`else
  modport master (output in_data, in_c0, in_c1, in_blank,
                  input  out_tmds, out_disparity);
  modport slave  (input  in_data, in_c0, in_c1, in_blank,
                  output out_tmds, out_disparity);
`endif
endinterface

// File: rtl/tmds_channel_encoder.sv
// tmds_channel_encoder
//   One lane of DVI TMDS 8b/10b encoding in the clk_pixel domain.
//   Pipeline: [A: optional input register] -> B: transition-minimised q_m
//   -> C: DC balancing / control symbol insertion with running disparity.
//   Latency is 3 clk_pixel with C_input_reg = 1, 2 with C_input_reg = 0.
//   Ports:
//     clk_pixel  pixel clock, rising edge
//     rst_n      asynchronous active-low reset
//     bus        tmds_channel_encoder_if.slave (pixel inputs, symbol outputs)
//   Optional feature macro: TMDS_TERC4_EN adds TERC4 data-island symbols
//   selected by in_island while blanking (video > island > control).
module tmds_channel_encoder #(
  parameter int C_input_reg = 1
) (
  input  logic                 clk_pixel,
  input  logic                 rst_n,
  tmds_channel_encoder_if.slave bus
);

  function automatic logic [9:0] ctrl_symbol(input logic c1, input logic c0);
    logic [9:0] sym;
    case ({c1, c0})
      2'b00:   sym = 10'b1101010100;
      2'b01:   sym = 10'b0010101011;
      2'b10:   sym = 10'b0101010100;
      default: sym = 10'b1010101011;
    endcase
    return sym;
  endfunction

`ifdef TMDS_TERC4_EN
  function automatic logic [9:0] terc4_symbol(input logic [3:0] nib);
    logic [9:0] sym;
    case (nib)
      4'h0:    sym = 10'b1010011100;
      4'h1:    sym = 10'b1001100011;
      4'h2:    sym = 10'b1011100100;
      4'h3:    sym = 10'b1011100010;
      4'h4:    sym = 10'b0101110001;
      4'h5:    sym = 10'b0100011110;
      4'h6:    sym = 10'b0110001110;
      4'h7:    sym = 10'b0100111100;
      4'h8:    sym = 10'b1011001100;
      4'h9:    sym = 10'b0100111001;
      4'hA:    sym = 10'b0110011100;
      4'hB:    sym = 10'b1011000110;
      4'hC:    sym = 10'b1010001110;
      4'hD:    sym = 10'b1001110001;
      4'hE:    sym = 10'b0101100011;
      default: sym = 10'b1011000011;
    endcase
    return sym;
  endfunction
`endif

  // Stage A outputs (registered or straight from the bus)
  logic [7:0] a_data;
  logic       a_c0, a_c1, a_blank;
`ifdef TMDS_TERC4_EN
  logic       a_island;
  logic [3:0] a_terc4;
`endif

  generate
    if (C_input_reg != 0) begin : g_in_reg
      logic [7:0] data_q;
      logic       c0_q, c1_q, blank_q;
`ifdef TMDS_TERC4_EN
      logic       island_q;
      logic [3:0] terc4_q;
`endif
      // Blank resets to 1 so a reset pipeline emits control symbols only.
      always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
          data_q   <= '0;
          c0_q     <= 1'b0;
          c1_q     <= 1'b0;
          blank_q  <= 1'b1;
`ifdef TMDS_TERC4_EN
          island_q <= 1'b0;
          terc4_q  <= '0;
`endif
        end else begin
          data_q   <= bus.in_data;
          c0_q     <= bus.in_c0;
          c1_q     <= bus.in_c1;
          blank_q  <= bus.in_blank;
`ifdef TMDS_TERC4_EN
          island_q <= bus.in_island;
          terc4_q  <= bus.in_terc4;
`endif
        end
      end
      assign a_data   = data_q;
      assign a_c0     = c0_q;
      assign a_c1     = c1_q;
      assign a_blank  = blank_q;
`ifdef TMDS_TERC4_EN
      assign a_island = island_q;
      assign a_terc4  = terc4_q;
`endif
    end else begin : g_no_in_reg
      assign a_data   = bus.in_data;
      assign a_c0     = bus.in_c0;
      assign a_c1     = bus.in_c1;
      assign a_blank  = bus.in_blank;
`ifdef TMDS_TERC4_EN
      assign a_island = bus.in_island;
      assign a_terc4  = bus.in_terc4;
`endif
    end
  endgenerate

  // Stage B: transition-minimised word q_m plus its ones/zeros counts
  logic [3:0] n1d;
  logic       xnor_mode;
  logic [8:0] qm_d, qm_q;
  logic [3:0] n1q_d, n1q_q, n0q_d, n0q_q;
  logic       b_blank_q, b_c0_q, b_c1_q;
`ifdef TMDS_TERC4_EN
  logic       b_island_q;
  logic [3:0] b_terc4_q;
`endif

  always_comb begin
    n1d = '0;
    for (int i = 0; i < 8; i++) n1d = n1d + {3'b000, a_data[i]};
    // XNOR chaining keeps heavy-ones words from toggling on every bit
    xnor_mode = (n1d > 4'd4) || ((n1d == 4'd4) && !a_data[0]);
    qm_d = '0;
    qm_d[0] = a_data[0];
    for (int i = 1; i < 8; i++)
      qm_d[i] = xnor_mode ? ~(qm_d[i-1] ^ a_data[i]) : (qm_d[i-1] ^ a_data[i]);
    qm_d[8] = ~xnor_mode;
    n1q_d = '0;
    for (int i = 0; i < 8; i++) n1q_d = n1q_d + {3'b000, qm_d[i]};
    n0q_d = 4'd8 - n1q_d;
  end

  // Stage C: DC balancing against the running disparity
  logic signed [4:0] cnt_d, cnt_q;
  logic signed [4:0] n1s, n0s, diff;
  logic [9:0]        tmds_d, tmds_q;

  always_comb begin
    n1s    = signed'({1'b0, n1q_q});
    n0s    = signed'({1'b0, n0q_q});
    diff   = n1s - n0s;
    tmds_d = tmds_q;
    cnt_d  = cnt_q;
    if (b_blank_q) begin
`ifdef TMDS_TERC4_EN
      if (b_island_q) tmds_d = terc4_symbol(b_terc4_q);
      else            tmds_d = ctrl_symbol(b_c1_q, b_c0_q);
`else
      tmds_d = ctrl_symbol(b_c1_q, b_c0_q);
`endif
      cnt_d = '0;
    end else if ((cnt_q == 5'sd0) || (n1q_q == n0q_q)) begin
      tmds_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
      cnt_d  = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
    end else if (((cnt_q > 5'sd0) && (n1q_q > n0q_q)) ||
                 ((cnt_q < 5'sd0) && (n0q_q > n1q_q))) begin
      // Inverting the payload pulls the disparity back towards zero
      tmds_d = {1'b1, qm_q[8], ~qm_q[7:0]};
      cnt_d  = cnt_q + (qm_q[8] ? 5'sd2 : 5'sd0) - diff;
    end else begin
      tmds_d = {1'b0, qm_q[8], qm_q[7:0]};
      cnt_d  = cnt_q + diff - (qm_q[8] ? 5'sd0 : 5'sd2);
    end
  end

  // Stage B and C registers; reset parks the lane on control symbol 00
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      qm_q       <= '0;
      n1q_q      <= '0;
      n0q_q      <= '0;
      b_blank_q  <= 1'b1;
      b_c0_q     <= 1'b0;
      b_c1_q     <= 1'b0;
`ifdef TMDS_TERC4_EN
      b_island_q <= 1'b0;
      b_terc4_q  <= '0;
`endif
      tmds_q     <= 10'b1101010100;
      cnt_q      <= '0;
    end else begin
      qm_q       <= qm_d;
      n1q_q      <= n1q_d;
      n0q_q      <= n0q_d;
      b_blank_q  <= a_blank;
      b_c0_q     <= a_c0;
      b_c1_q     <= a_c1;
`ifdef TMDS_TERC4_EN
      b_island_q <= a_island;
      b_terc4_q  <= a_terc4;
`endif
      tmds_q     <= tmds_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.out_tmds      = tmds_q;
  assign bus.out_disparity = cnt_q;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// tb_tmds_channel_encoder
//   Drives the same pixel stream into two encoders (input register on and
//   off) and checks both against a scoreboard of expected symbols.
//   Optional feature macro: TMDS_TERC4_EN enables the data-island checks.
module tb_tmds_channel_encoder;

`ifdef TMDS_TERC4_EN
  localparam bit TERC_ON = 1'b1;
`else
  localparam bit TERC_ON = 1'b0;
`endif

  typedef struct {
    logic [9:0] tmds;
    logic [4:0] disp;
    int         due;
  } exp_t;

  logic clk_pixel = 1'b0;
  logic rst_n     = 1'b0;
  int   cyc       = 0;
  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   model_cnt    = 0;
  exp_t q3[$];
  exp_t q2[$];

  logic [9:0] terc_table [16] = '{10'h29C, 10'h263, 10'h2E4, 10'h2E2,
                                  10'h171, 10'h11E, 10'h18E, 10'h13C,
                                  10'h2CC, 10'h139, 10'h19C, 10'h2C6,
                                  10'h28E, 10'h271, 10'h163, 10'h2C3};

  tmds_channel_encoder_if bus3 ();
  tmds_channel_encoder_if bus2 ();

  tmds_channel_encoder #(.C_input_reg(1)) dut3 (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .bus       (bus3)
  );

  tmds_channel_encoder #(.C_input_reg(0)) dut2 (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .bus       (bus2)
  );

  always #5 clk_pixel = ~clk_pixel;

  always @(posedge clk_pixel) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, observed,
               expected, cyc);
    end
  endtask

  // Reference encoder: returns the symbol and advances model_cnt
  task automatic modelSymbol(input logic [7:0] d, input logic c0, input logic c1,
                             input logic blank, input logic island,
                             input logic [3:0] terc4, output logic [9:0] sym);
    int n1d, n1q, n0q;
    logic use_xnor;
    logic [8:0] qm;
    if (blank) begin
      if (island && TERC_ON) sym = terc_table[terc4];
      else begin
        case ({c1, c0})
          2'b00:   sym = 10'h354;
          2'b01:   sym = 10'h0AB;
          2'b10:   sym = 10'h154;
          default: sym = 10'h2AB;
        endcase
      end
      model_cnt = 0;
    end else begin
      n1d = $countones(d);
      use_xnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
      qm = '0;
      qm[0] = d[0];
      for (int i = 1; i < 8; i++)
        qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = !use_xnor;
      n1q = $countones(qm[7:0]);
      n0q = 8 - n1q;
      if (model_cnt == 0 || n1q == n0q) begin
        sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        model_cnt += qm[8] ? (n1q - n0q) : (n0q - n1q);
      end else if ((model_cnt > 0 && n1q > n0q) || (model_cnt < 0 && n0q > n1q)) begin
        sym = {1'b1, qm[8], ~qm[7:0]};
        model_cnt += (qm[8] ? 2 : 0) + n0q - n1q;
      end else begin
        sym = {1'b0, qm[8], qm[7:0]};
        model_cnt += n1q - n0q - (qm[8] ? 0 : 2);
      end
    end
  endtask

  task automatic driveInputs(input logic [7:0] d, input logic c0, input logic c1,
                             input logic blank, input logic island,
                             input logic [3:0] terc4);
    bus3.in_data = d;  bus3.in_c0 = c0;  bus3.in_c1 = c1;  bus3.in_blank = blank;
    bus2.in_data = d;  bus2.in_c0 = c0;  bus2.in_c1 = c1;  bus2.in_blank = blank;
`ifdef TMDS_TERC4_EN
    bus3.in_island = island;  bus3.in_terc4 = terc4;
    bus2.in_island = island;  bus2.in_terc4 = terc4;
`endif
  endtask

  task automatic pushExpected(input logic [9:0] sym, input logic [4:0] disp);
    exp_t e;
    e.tmds = sym;
    e.disp = disp;
    e.due  = cyc + 3;
    q3.push_back(e);
    e.due  = cyc + 2;
    q2.push_back(e);
  endtask

  // One pixel with the expectation taken from the reference encoder
  task automatic applyStimulus(input logic [7:0] d, input logic c0, input logic c1,
                               input logic blank, input logic island,
                               input logic [3:0] terc4);
    logic [9:0] sym;
    @(posedge clk_pixel);
    #1;
    driveInputs(d, c0, c1, blank, island, terc4);
    modelSymbol(d, c0, c1, blank, island, terc4, sym);
    pushExpected(sym, model_cnt[4:0]);
  endtask

  // One pixel with a hand-derived expected symbol and disparity
  task automatic applyKnown(input logic [7:0] d, input logic c0, input logic c1,
                            input logic blank, input logic island,
                            input logic [3:0] terc4, input logic [9:0] exp_sym,
                            input int exp_disp);
    logic [9:0] sym;
    logic [4:0] disp5;
    @(posedge clk_pixel);
    #1;
    driveInputs(d, c0, c1, blank, island, terc4);
    modelSymbol(d, c0, c1, blank, island, terc4, sym);
    disp5 = exp_disp[4:0];
    pushExpected(exp_sym, disp5);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_tmds3"}, {6'd0, bus3.out_tmds}, 16'h0354);
    checkOutput({tag, "_disp3"}, {11'd0, bus3.out_disparity}, 16'h0000);
    checkOutput({tag, "_tmds2"}, {6'd0, bus2.out_tmds}, 16'h0354);
    checkOutput({tag, "_disp2"}, {11'd0, bus2.out_disparity}, 16'h0000);
  endtask

  // Scoreboard: pop and compare each expectation on its due cycle
  always @(negedge clk_pixel) begin
    exp_t e;
    while (q3.size() > 0 && q3[0].due <= cyc) begin
      e = q3.pop_front();
      if (e.due < cyc) checkOutput("late3", cyc[15:0], e.due[15:0]);
      else begin
        checkOutput("tmds3", {6'd0, bus3.out_tmds}, {6'd0, e.tmds});
        checkOutput("disp3", {11'd0, bus3.out_disparity}, {11'd0, e.disp});
      end
    end
    while (q2.size() > 0 && q2[0].due <= cyc) begin
      e = q2.pop_front();
      if (e.due < cyc) checkOutput("late2", cyc[15:0], e.due[15:0]);
      else begin
        checkOutput("tmds2", {6'd0, bus2.out_tmds}, {6'd0, e.tmds});
        checkOutput("disp2", {11'd0, bus2.out_disparity}, {11'd0, e.disp});
      end
    end
  end

  task automatic resetPulse();
    @(posedge clk_pixel);
    #1;
    rst_n = 1'b0;
    q3.delete();
    q2.delete();
    model_cnt = 0;
    driveInputs(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    @(negedge clk_pixel);
    checkResetState("in_reset");
    @(posedge clk_pixel);
    #1;
    driveInputs(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    @(posedge clk_pixel);
    @(negedge clk_pixel);
    rst_n = 1'b1;
    @(negedge clk_pixel);
    checkResetState("after_release");
  endtask

  initial begin
    driveInputs(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    @(negedge clk_pixel);
    checkResetState("power_on");
    @(posedge clk_pixel);
    @(negedge clk_pixel);
    rst_n = 1'b1;
    @(negedge clk_pixel);
    checkResetState("first_release");

    // Control symbols
    applyKnown(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 10'h354, 0);
    applyKnown(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 10'h0AB, 0);
    applyKnown(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 10'h154, 0);
    applyKnown(8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 10'h2AB, 0);
    applyKnown(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 10'h354, 0);

    // Zero pixels swing the disparity both ways
    applyKnown(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'h100, -8);
    applyKnown(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'h3FF, 2);
    applyKnown(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'h100, -6);
    applyKnown(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 10'h354, 0);

    // All-ones pixel in XNOR mode, then back to blank
    applyKnown(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'h200, -8);
    applyKnown(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 10'h354, 0);

`ifdef TMDS_TERC4_EN
    applyKnown(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 10'h29C, 0);
    applyKnown(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 10'h2C3, 0);
    applyKnown(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 10'h133, 0);
    applyKnown(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 10'h354, 0);
    for (int i = 0; i < 16; i++)
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 4'(i));
`endif

    // Mixed random video with occasional blanking and islands
    for (int i = 0; i < 150; i++)
      applyStimulus(8'($urandom_range(255)), 1'($urandom_range(1)),
                    1'($urandom_range(1)), ($urandom_range(7) == 0),
                    1'($urandom_range(1)), 4'($urandom_range(15)));

    // Reset in the middle of active video discards in-flight symbols
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    applyStimulus(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    resetPulse();
    applyKnown(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 10'h354, 0);
    applyKnown(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'h100, -8);
    for (int i = 0; i < 20; i++)
      applyStimulus(8'($urandom_range(255)), 1'b0, 1'b0, ($urandom_range(5) == 0),
                    1'b0, 4'h0);

    // Drain and confirm every expectation was consumed
    repeat (4) @(posedge clk_pixel);
    @(negedge clk_pixel);
    #1;
    checkOutput("drain3", q3.size(), 16'd0);
    checkOutput("drain2", q2.size(), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/tmds_channel_encoder.md
Name: tmds_channel_encoder

Overview:
- One lane of DVI 1.0 TMDS 8b/10b encoding.
- Sits between the VGA timing/pixel generator and the fake-differential serializer stage, in the clk_pixel domain.
- One instance per colour lane. The blue lane carries hsync/vsync on c0/c1; red and green tie c0/c1 low.
- Pipelined 8b/10b encoding with running-disparity tracking and control-symbol insertion during blanking. Output is a 10-bit parallel symbol for a 10:1 (SDR) or 5:1 (DDR) shifter.

Parameters:
- C_input_reg, 1: 1 = register data/c0/c1/blank on entry (total latency 3 clk_pixel); 0 = no input register (latency 2).

Ports:
- clk_pixel  input  1  pixel clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  8  pixel component
- in_c0  input  1  control bit 0, sent during blank
- in_c1  input  1  control bit 1, sent during blank
- in_blank  input  1  1 = blanking period (control or island symbols), 0 = active video
- out_tmds  output  10  encoded symbol; bit 0 transmitted first
- out_disparity  output  5  signed running disparity after the current out_tmds symbol

Behaviour:
- Reset (async assert, sync-clean release):
  - all pipeline registers clear, blank stages forced to 1, c0/c1 to 0
  - out_tmds = 10'b1101010100 (control 00); out_disparity = 0
  - Reset mid-frame discards in-flight symbols. First valid output appears latency cycles after release.
- Stage A (optional input register, per C_input_reg): capture in_data, in_c0, in_c1, in_blank.
- Stage B:
  - n1d = ones count of data (4 bits).
  - XNOR mode if n1d > 4, or n1d == 4 and data[0] == 0; else XOR mode.
  - q_m[0] = d[0]; q_m[i] = q_m[i-1] XOR d[i], inverted in XNOR mode; q_m[8] = 1 for XOR, 0 for XNOR.
  - Register q_m[8:0], n1q and n0q (ones/zeros of q_m[7:0]), blank, c0, c1.
- Stage C (output register, running disparity cnt, 5-bit signed, range -8..+8 inclusive):
  - When blank = 1: out = control symbol by {c1,c0}: 00 → 1101010100, 01 → 0010101011, 10 → 0101010100, 11 → 1010101011 (written bit9..bit0). cnt = 0.
  - Case cnt == 0 or n1q == n0q:
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}
    - if q_m[8] = 1, cnt += n1q - n0q; else cnt += n0q - n1q
  - Case (cnt > 0 and n1q > n0q) or (cnt < 0 and n0q > n1q):
    - out = {1, q_m[8], ~q_m[7:0]}
    - cnt += 2*q_m[8] + n0q - n1q
  - Otherwise:
    - out = {0, q_m[8], q_m[7:0]}
    - cnt += n1q - n0q - 2*(~q_m[8])
- Arithmetic: signed, sized to 5 bits before addition; no saturation needed (bounded by the algorithm).
- Blank/active transitions take effect on the exact pixel carried through the pipeline; there are no extra idle cycles.
- out_disparity equals cnt after the update for the current symbol.

Optional Feature:
- TMDS_TERC4_EN defined:
  - Adds ports in_island (input, 1) and in_terc4 (input, 4), pipelined alongside the other inputs.
  - When blank = 1 and island = 1, out = TERC4 code (bit9..bit0), cnt = 0:
    - 0:1010011100 1:1001100011 2:1011100100 3:1011100010
    - 4:0101110001 5:0100011110 6:0110001110 7:0100111100
    - 8:1011001100 9:0100111001 A:0110011100 B:1011000110
    - C:1010001110 D:1001110001 E:0101100011 F:1011000011
  - Priority: video > island > control.
- Undefined: ports absent; blank always yields control symbols.

Test Plan:
- Reset asserted mid-stream, then released with blank = 1, {c1,c0} = 00 → out_tmds = 10'h354 immediately on reset and through latency; out_disparity = 0.
- Blank, with {c1,c0} = 01, 10, 11 on consecutive cycles → 10'h0AB, 10'h154, 10'h2AB in order after latency; disparity stays 0.
- After blank, in_data = 0x00 for three pixels → out_tmds = 10'h100, 10'h3FF, 10'h100; out_disparity = -8, +2, -6.
- After blank, in_data = 0xFF once → out_tmds = 10'h200, out_disparity = -8. Then blank → 10'h354, disparity 0.
- C_input_reg = 0 vs 1, same stimulus → identical symbol stream, offset by exactly one clk_pixel.
- With TMDS_TERC4_EN: blank = 1, island = 1, terc4 = 0x0 then 0xF → 10'h29C then 10'h2C3. Driving in_blank = 0 during island → video encoding takes priority.
